// File: rtl/pool_window_gen.sv
// Sliding K x K pooling window generator over a raster pixel stream.
// Line buffers hold the previous K-1 lines; a per-row shift register forms the window columns.
module pool_window_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIN_SIZE   = 3,
  parameter int unsigned STRIDE     = 2,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned IMG_HEIGHT = 16
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  din_vld,
  input  logic signed [DATA_WIDTH-1:0]                          din,
  output logic                                                  dout_vld,
  output logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] dout,
  output logic                                                  frame_done
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned LB_N  = WIN_SIZE - 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // line_buf[0] holds the line just above the current one, line_buf[LB_N-1] the oldest
  logic [DATA_WIDTH-1:0] line_buf [LB_N][IMG_WIDTH];

  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win_q;
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win_nxt;
  logic [WIN_SIZE-1:0][DATA_WIDTH-1:0]               col_pix;

  logic last_col;
  logic last_row;
  logic is_anchor;

  // Column of K vertically aligned pixels, then shift it into the window
  always_comb begin
    col_pix = '0;
    win_nxt = '0;
    col_pix[WIN_SIZE-1] = din;
    for (int i = 0; i < int'(LB_N); i++) begin
      col_pix[WIN_SIZE-2-i] = line_buf[i][col];
    end
    for (int r = 0; r < int'(WIN_SIZE); r++) begin
      for (int c = 0; c < int'(WIN_SIZE) - 1; c++) begin
        win_nxt[r][c] = win_q[r][c+1];
      end
      win_nxt[r][WIN_SIZE-1] = col_pix[r];
    end
  end

  // Anchors only exist once K full lines/columns of this frame are present,
  // so stale buffer contents can never reach an emitted window
  always_comb begin
    last_col  = (col == COL_W'(IMG_WIDTH - 1));
    last_row  = (row == ROW_W'(IMG_HEIGHT - 1));
    is_anchor = (32'(row) >= 32'(WIN_SIZE - 1)) &&
                (32'(col) >= 32'(WIN_SIZE - 1)) &&
                (((32'(row) - 32'(WIN_SIZE - 1)) % 32'(STRIDE)) == 32'd0) &&
                (((32'(col) - 32'(WIN_SIZE - 1)) % 32'(STRIDE)) == 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
      dout       <= '0;
    end else begin
      dout_vld   <= din_vld && is_anchor;
      frame_done <= din_vld && last_col && last_row;
      if (din_vld && is_anchor) begin
        dout <= win_nxt;
      end
      if (din_vld) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Data storage carries no reset; validity is governed by the counters alone
  always_ff @(posedge clk) begin
    if (din_vld) begin
      win_q <= win_nxt;
      line_buf[0][col] <= din;
      for (int i = 1; i < int'(LB_N); i++) begin
        line_buf[i][col] <= line_buf[i-1][col];
      end
    end
  end

endmodule
